// File: rtl/norm_chk_sequencer.sv
// Streams polynomial words from memory and checks every coefficient
// against the infinity-norm bound of the selected mode, constant-time.
module norm_chk_sequencer #(
  parameter int REG_SIZE       = 24,
  parameter int MLDSA_Q        = 8380417,
  parameter int ADDR_W         = 15,
  parameter int COEFF_PER_WORD = 4,
  parameter int WORDS_PER_POLY = 64
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   zeroize,
  input  logic                                   norm_check_enable,
  input  logic [1:0]                             mode,
  input  logic [ADDR_W-1:0]                      mem_base_addr,
  input  logic [3:0]                             num_poly,
  output logic                                   mem_rd_en,
  output logic [ADDR_W-1:0]                      mem_rd_addr,
  input  logic [COEFF_PER_WORD*(REG_SIZE-1)-1:0] mem_rd_data,
  output logic                                   norm_check_ready,
  output logic                                   norm_check_done,
  output logic                                   invalid
);

  localparam int CW     = REG_SIZE - 1;
  localparam int CNT_W  = $clog2(16 * WORDS_PER_POLY);
  localparam int GAMMA1 = 1 << 19;
  localparam int GAMMA2 = (MLDSA_Q - 1) / 32;
  localparam int BETA   = 120;

  localparam logic [REG_SIZE-1:0] Q_V =
    REG_SIZE'(MLDSA_Q);
  localparam logic [REG_SIZE-1:0] Z_BND =
    REG_SIZE'(GAMMA1 - BETA);
  localparam logic [REG_SIZE-1:0] R0_BND =
    REG_SIZE'(GAMMA2 - BETA);
  localparam logic [REG_SIZE-1:0] CT0_BND =
    REG_SIZE'(GAMMA2);

  typedef enum logic [1:0] {
    MODE_Z,
    MODE_R0,
    MODE_CT0,
    MODE_RSVD
  } chk_norm_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  state_t               state_q, state_d;
  chk_norm_mode_t       mode_q;
  logic [ADDR_W-1:0]    base_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     last_q;
  logic [CNT_W-1:0]     last_d;
  logic [CNT_W-1:0]     np_ext;
  logic                 dv_q;
  logic                 invalid_q;
  logic                 start;
  logic                 word_flag;
  logic [REG_SIZE-1:0]  bnd_lo;
  logic [REG_SIZE-1:0]  bnd_hi;

  assign start = (state_q == IDLE) && norm_check_enable;

  always_comb begin
    np_ext = (num_poly == 4'd0) ? CNT_W'(1) : CNT_W'(num_poly);
    last_d = np_ext * CNT_W'(WORDS_PER_POLY) - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else if (zeroize) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (norm_check_enable) state_d = READ;
      READ:  if (cnt_q == last_q) state_d = DRAIN;
      DRAIN: state_d = DONE;
      DONE:  state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en        = (state_q == READ);
    mem_rd_addr      = '0;
    if (mem_rd_en) mem_rd_addr = base_q + ADDR_W'(cnt_q);
    norm_check_ready = (state_q == IDLE);
    norm_check_done  = (state_q == DONE);
  end

  // Reserved mode uses bound 0, so every coefficient lands in the window.
  always_comb begin
    bnd_lo = '0;
    unique case (mode_q)
      MODE_Z:    bnd_lo = Z_BND;
      MODE_R0:   bnd_lo = R0_BND;
      MODE_CT0:  bnd_lo = CT0_BND;
      MODE_RSVD: bnd_lo = '0;
    endcase
    bnd_hi = Q_V - bnd_lo;
  end

  always_comb begin
    word_flag = 1'b0;
    for (int i = 0; i < COEFF_PER_WORD; i++) begin
      word_flag = word_flag |
        (({1'b0, mem_rd_data[i*CW +: CW]} >= bnd_lo) &&
         ({1'b0, mem_rd_data[i*CW +: CW]} <= bnd_hi));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q    <= MODE_Z;
      base_q    <= '0;
      cnt_q     <= '0;
      last_q    <= '0;
      dv_q      <= 1'b0;
      invalid_q <= 1'b0;
    end else if (zeroize) begin
      mode_q    <= MODE_Z;
      base_q    <= '0;
      cnt_q     <= '0;
      last_q    <= '0;
      dv_q      <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      dv_q <= mem_rd_en;
      if (start) begin
        mode_q    <= chk_norm_mode_t'(mode);
        base_q    <= mem_base_addr;
        last_q    <= last_d;
        cnt_q     <= '0;
        invalid_q <= 1'b0;
      end else begin
        if (mem_rd_en) cnt_q <= cnt_q + CNT_W'(1);
        if (dv_q && word_flag) invalid_q <= 1'b1;
      end
    end
  end

  assign invalid = invalid_q;

endmodule

// File: tb/tb_norm_chk_sequencer.sv
// Randomised bench for norm_chk_sequencer with a memory model
// and a coefficient-level reference for the invalid result.
module tb_norm_chk_sequencer;

  localparam int Q      = 8380417;
  localparam int GAMMA1 = 524288;
  localparam int GAMMA2 = 261888;
  localparam int BETA   = 120;
  localparam int WPP    = 64;
  localparam int AW     = 15;
  localparam int DEPTH  = 32768;
  localparam int DW     = 92;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          zeroize;
  logic          norm_check_enable;
  logic [1:0]    mode;
  logic [AW-1:0] mem_base_addr;
  logic [3:0]    num_poly;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic          norm_check_ready;
  logic          norm_check_done;
  logic          invalid;

  int tests_run = 0;
  int failed    = 0;

  logic [DW-1:0] mem [DEPTH];

  int   obs_addr[$];
  int   obs_first, obs_last, obs_ndone, obs_done_cyc;
  int   obs_bad_idle, obs_rdy_busy;
  logic obs_inv_done, obs_rdy_after, obs_inv_after, obs_inv_hold;
  bit   obs_timeout;

  norm_chk_sequencer dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .zeroize           (zeroize),
    .norm_check_enable (norm_check_enable),
    .mode              (mode),
    .mem_base_addr     (mem_base_addr),
    .num_poly          (num_poly),
    .mem_rd_en         (mem_rd_en),
    .mem_rd_addr       (mem_rd_addr),
    .mem_rd_data       (mem_rd_data),
    .norm_check_ready  (norm_check_ready),
    .norm_check_done   (norm_check_done),
    .invalid           (invalid)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  function automatic int bound_of(input int md);
    case (md)
      0:       return GAMMA1 - BETA;
      1:       return GAMMA2 - BETA;
      2:       return GAMMA2;
      default: return 0;
    endcase
  endfunction

  function automatic int words_of(input int np);
    return (np == 0 ? 1 : np) * WPP;
  endfunction

  // A coefficient violates when bound <= c <= Q - bound.
  function automatic bit model_invalid(input int md, input int base,
                                       input int np);
    int b = bound_of(md);
    for (int k = 0; k < words_of(np); k++) begin
      int a = (base + k) % DEPTH;
      for (int i = 0; i < 4; i++) begin
        int c = int'(mem[a][i*23 +: 23]);
        if (c >= b && c <= Q - b) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic set_coeff(input int a, input int idx, input int v);
    mem[a % DEPTH][idx*23 +: 23] = 23'(v);
  endtask

  task automatic clear_range(input int base, input int n);
    for (int k = 0; k < n; k++) mem[(base + k) % DEPTH] = '0;
  endtask

  function automatic int safe_coeff(input int b);
    int r;
    if (b == 0) return int'($urandom_range(0, Q - 1));
    r = int'($urandom_range(0, 5));
    case (r)
      0:       return b - 1;
      1:       return Q - b + 1;
      2:       return 0;
      3:       return Q - 1;
      4:       return int'($urandom_range(0, b - 1));
      default: return Q - int'($urandom_range(1, b - 1));
    endcase
  endfunction

  task automatic fill_random(input int md, input int base, input int n);
    int b = bound_of(md);
    int nviol;
    for (int k = 0; k < n; k++)
      for (int i = 0; i < 4; i++) set_coeff(base + k, i, safe_coeff(b));
    nviol = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 2));
    for (int v = 0; v < nviol; v++) begin
      int r = int'($urandom_range(0, 2));
      int val = (r == 0) ? b : (r == 1) ? Q - b :
                int'($urandom_range(b, Q - b));
      set_coeff(base + int'($urandom_range(0, n - 1)),
                int'($urandom_range(0, 3)), val);
    end
  endtask

  // Drives one start (edge 0) and records what the DUT does per cycle.
  task automatic run_seq(input int md, input int base, input int np,
                         input int zero_at, input int busy_at);
    obs_addr.delete();
    obs_first = -1; obs_last = -1; obs_ndone = 0; obs_done_cyc = -1;
    obs_bad_idle = 0; obs_rdy_busy = 0; obs_timeout = 1'b1;
    obs_inv_done = 1'b0; obs_rdy_after = 1'b0;
    obs_inv_after = 1'b0; obs_inv_hold = 1'b0;
    @(negedge clk);
    mode = 2'(md); mem_base_addr = AW'(base); num_poly = 4'(np);
    norm_check_enable = 1'b1;
    @(negedge clk);
    norm_check_enable = 1'b0;
    mode = 2'($urandom); mem_base_addr = AW'($urandom);
    num_poly = 4'($urandom);
    for (int cyc = 1; cyc <= 2100; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (mem_rd_en) begin
        obs_addr.push_back(int'(mem_rd_addr));
        if (obs_first < 0) obs_first = cyc;
        obs_last = cyc;
      end else if (mem_rd_addr != '0) obs_bad_idle++;
      if (norm_check_ready && obs_done_cyc < 0 &&
          (zero_at < 0 || cyc <= zero_at)) obs_rdy_busy++;
      if (norm_check_done) begin
        obs_ndone++; obs_done_cyc = cyc; obs_inv_done = invalid;
      end
      if (zero_at >= 0 && cyc == zero_at + 1) begin
        obs_rdy_after = norm_check_ready; obs_inv_after = invalid;
        zeroize = 1'b0;
      end
      if (zero_at >= 0 && cyc == zero_at + 6) begin
        obs_timeout = 1'b0; break;
      end
      if (zero_at < 0 && obs_done_cyc >= 0 && cyc == obs_done_cyc + 1) begin
        obs_rdy_after = norm_check_ready; obs_inv_after = invalid;
      end
      if (zero_at < 0 && obs_done_cyc >= 0 && cyc == obs_done_cyc + 4) begin
        obs_inv_hold = invalid; obs_timeout = 1'b0; break;
      end
      if (cyc == zero_at) zeroize = 1'b1;
      if (cyc == busy_at) begin
        norm_check_enable = 1'b1; mem_base_addr = AW'($urandom);
        num_poly = 4'($urandom_range(1, 15)); mode = 2'($urandom);
      end
      if (cyc == busy_at + 1) norm_check_enable = 1'b0;
    end
    norm_check_enable = 1'b0;
    zeroize = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    tests_run++; if (norm_check_ready !== 1'b1) begin failed++; $display("FAIL rst_ready: got %b want 1", norm_check_ready); end
    tests_run++; if (norm_check_done !== 1'b0) begin failed++; $display("FAIL rst_done: got %b want 0", norm_check_done); end
    tests_run++; if (mem_rd_en !== 1'b0) begin failed++; $display("FAIL rst_rd_en: got %b want 0", mem_rd_en); end
    tests_run++; if (mem_rd_addr !== '0) begin failed++; $display("FAIL rst_rd_addr: got %h want 0", mem_rd_addr); end
    tests_run++; if (invalid !== 1'b0) begin failed++; $display("FAIL rst_invalid: got %b want 0", invalid); end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    tests_run++; if (norm_check_ready !== 1'b1) begin failed++; $display("FAIL rst_ready_post: got %b want 1", norm_check_ready); end
  endtask

  task automatic test_z_zero();
    int base = int'($urandom_range(0, DEPTH - 1));
    int bad = 0;
    clear_range(base, 64);
    run_seq(0, base, 1, -1, -1);
    for (int k = 0; k < 64; k++)
      if (k >= obs_addr.size() || obs_addr[k] != (base + k) % DEPTH) bad++;
    tests_run++; if (obs_timeout) begin failed++; $display("FAIL z_timeout: no done within budget"); end
    tests_run++; if (obs_addr.size() != 64 || bad != 0) begin failed++; $display("FAIL z_addr_seq: got %0d reads (%0d wrong) want 64 at base %h", obs_addr.size(), bad, base); end
    tests_run++; if (obs_first != 1 || obs_last != 64) begin failed++; $display("FAIL z_read_cycles: got %0d..%0d want 1..64", obs_first, obs_last); end
    tests_run++; if (obs_done_cyc != 66 || obs_ndone != 1) begin failed++; $display("FAIL z_done: got cycle %0d count %0d want 66 x1", obs_done_cyc, obs_ndone); end
    tests_run++; if (obs_inv_done !== 1'b0) begin failed++; $display("FAIL z_invalid: got %b want 0", obs_inv_done); end
    tests_run++; if (obs_rdy_after !== 1'b1 || obs_rdy_busy != 0) begin failed++; $display("FAIL z_ready: after %b busy-high %0d want 1/0", obs_rdy_after, obs_rdy_busy); end
    tests_run++; if (obs_bad_idle != 0) begin failed++; $display("FAIL z_idle_addr: got %0d nonzero want 0", obs_bad_idle); end
  endtask

  task automatic test_r0_boundary();
    int vals[4] = '{GAMMA2 - BETA, GAMMA2 - BETA - 1,
                    Q - (GAMMA2 - BETA) + 1, Q - (GAMMA2 - BETA)};
    logic exp_inv[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int t = 0; t < 4; t++) begin
      int base = int'($urandom_range(0, DEPTH - 1));
      clear_range(base, 64);
      set_coeff(base + 63, int'($urandom_range(0, 3)), vals[t]);
      run_seq(1, base, 1, -1, -1);
      tests_run++; if (obs_inv_done !== exp_inv[t] || obs_timeout) begin failed++; $display("FAIL r0_bound[%0d]: coeff %0d got %b want %b", t, vals[t], obs_inv_done, exp_inv[t]); end
      tests_run++; if (obs_inv_hold !== exp_inv[t]) begin failed++; $display("FAIL r0_sticky[%0d]: got %b want %b", t, obs_inv_hold, exp_inv[t]); end
    end
  endtask

  task automatic test_ct0_early();
    int base = int'($urandom_range(0, DEPTH - 1));
    clear_range(base, 448);
    set_coeff(base, int'($urandom_range(0, 3)), GAMMA2);
    run_seq(2, base, 7, -1, -1);
    tests_run++; if (obs_addr.size() != 448 || obs_last != 448) begin failed++; $display("FAIL ct0_reads: got %0d last %0d want 448", obs_addr.size(), obs_last); end
    tests_run++; if (obs_done_cyc != 450 || obs_ndone != 1) begin failed++; $display("FAIL ct0_done: got cycle %0d count %0d want 450 x1", obs_done_cyc, obs_ndone); end
    tests_run++; if (obs_inv_done !== 1'b1) begin failed++; $display("FAIL ct0_invalid: got %b want 1", obs_inv_done); end
  endtask

  task automatic test_wrap_busy();
    int base = 'h7FF0;
    int bad = 0;
    clear_range(base, 64);
    run_seq(0, base, 1, -1, 10);
    for (int k = 0; k < 64; k++)
      if (k >= obs_addr.size() || obs_addr[k] != (base + k) % DEPTH) bad++;
    tests_run++; if (obs_addr.size() != 64 || bad != 0) begin failed++; $display("FAIL wrap_addr: got %0d reads (%0d wrong) want 64", obs_addr.size(), bad); end
    tests_run++; if (obs_addr.size() > 16 && (obs_addr[15] != 'h7FFF || obs_addr[16] != 0)) begin failed++; $display("FAIL wrap_edge: got %h,%h want 7fff,0000", obs_addr[15], obs_addr[16]); end
    tests_run++; if (obs_done_cyc != 66 || obs_ndone != 1) begin failed++; $display("FAIL busy_ignore: done cycle %0d count %0d want 66 x1", obs_done_cyc, obs_ndone); end
  endtask

  task automatic test_zeroize();
    int base = int'($urandom_range(0, DEPTH - 1));
    clear_range(base, 128);
    set_coeff(base, 0, GAMMA2 + 5);
    run_seq(2, base, 2, 30, -1);
    tests_run++; if (obs_ndone != 0 || obs_timeout) begin failed++; $display("FAIL zero_no_done: got %0d pulses want 0", obs_ndone); end
    tests_run++; if (obs_rdy_after !== 1'b1 || obs_inv_after !== 1'b0) begin failed++; $display("FAIL zero_state: ready %b invalid %b want 1/0", obs_rdy_after, obs_inv_after); end
    tests_run++; if (obs_last != 30 || obs_bad_idle != 0) begin failed++; $display("FAIL zero_reads: last read %0d idle-addr %0d want 30/0", obs_last, obs_bad_idle); end
    clear_range(base, 128);
    run_seq(2, base, 2, -1, -1);
    tests_run++; if (obs_done_cyc != 130 || obs_ndone != 1 || obs_inv_done !== 1'b0) begin failed++; $display("FAIL zero_fresh: done %0d x%0d inv %b want 130 x1 0", obs_done_cyc, obs_ndone, obs_inv_done); end
  endtask

  task automatic test_reserved();
    int base = int'($urandom_range(0, DEPTH - 1));
    clear_range(base, 64);
    run_seq(3, base, 1, -1, -1);
    tests_run++; if (obs_inv_done !== 1'b1 || obs_done_cyc != 66) begin failed++; $display("FAIL rsvd: invalid %b done %0d want 1 at 66", obs_inv_done, obs_done_cyc); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int md = int'($urandom_range(0, 3));
      int base = int'($urandom_range(0, DEPTH - 1));
      int np = (it == 0) ? 0 : int'($urandom_range(1, 4));
      int n = words_of(np);
      logic exp_inv;
      fill_random(md, base, n);
      exp_inv = model_invalid(md, base, np);
      run_seq(md, base, np, -1, -1);
      tests_run++; if (obs_inv_done !== exp_inv || obs_inv_hold !== exp_inv) begin failed++; $display("FAIL rand_inv[%0d]: mode %0d got %b/%b want %b", it, md, obs_inv_done, obs_inv_hold, exp_inv); end
      tests_run++; if (obs_addr.size() != n || obs_done_cyc != n + 2 || obs_ndone != 1) begin failed++; $display("FAIL rand_shape[%0d]: reads %0d done %0d want %0d/%0d", it, obs_addr.size(), obs_done_cyc, n, n + 2); end
    end
  endtask

  task automatic test_async_reset();
    int base = int'($urandom_range(0, DEPTH - 1));
    @(negedge clk);
    mode = 2'd0; mem_base_addr = AW'(base); num_poly = 4'd1;
    norm_check_enable = 1'b1;
    @(negedge clk);
    norm_check_enable = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    tests_run++; if (mem_rd_en !== 1'b0 || norm_check_ready !== 1'b1) begin failed++; $display("FAIL async_rst: rd_en %b ready %b want 0/1", mem_rd_en, norm_check_ready); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; zeroize = 1'b0; norm_check_enable = 1'b0;
    mode = 2'd0; mem_base_addr = '0; num_poly = 4'd0;
    for (int a = 0; a < DEPTH; a++) mem[a] = '0;
    test_reset();
    test_z_zero();
    test_r0_boundary();
    test_ct0_early();
    test_wrap_busy();
    test_zeroize();
    test_reserved();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
